// File: rtl/control_unit.sv
// Single-cycle decode/execute unit: 32 x 8-bit register file, ALU and status flags.
// Outputs are registered and reflect the instruction sampled at the previous rising edge.
module control_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   output logic [7:0]  number,
   output logic [3:0]  opcode,
   output logic [4:0]  addr1,
   output logic [4:0]  addr2,
   output logic [4:0]  addr3,
   output logic [3:0]  theflag,
   output logic [7:0]  output1
);

   typedef enum logic [3:0] {
      OpNop  = 4'd0,
      OpAdd  = 4'd1,
      OpSub  = 4'd2,
      OpAnd  = 4'd3,
      OpOr   = 4'd4,
      OpXor  = 4'd5,
      OpNot  = 4'd6,
      OpShl  = 4'd7,
      OpShr  = 4'd8,
      OpAddi = 4'd9,
      OpLdi  = 4'd10,
      OpMov  = 4'd11,
      OpCmp  = 4'd12,
      OpInc  = 4'd13,
      OpDec  = 4'd14,
      OpOut  = 4'd15
   } op_e;

   logic [7:0] r_regs [32];
   logic [7:0] r_number;
   logic [3:0] r_opcode;
   logic [4:0] r_addr1;
   logic [4:0] r_addr2;
   logic [4:0] r_addr3;
   logic [3:0] r_flags;
   logic [7:0] r_out;

   op_e        w_op;
   logic [4:0] w_dst;
   logic [4:0] w_src_a;
   logic [4:0] w_src_b;
   logic [7:0] w_imm;
   logic [7:0] w_a;
   logic [7:0] w_b;
   logic [7:0] w_rhs;
   logic [8:0] w_sum;
   logic [7:0] w_res;
   logic       w_c;
   logic       w_v;
   logic       w_we;
   logic       w_upd_flags;
   logic       w_upd_out;
   logic       w_unused_rsvd;

   assign w_op          = op_e'(addr[31:28]);
   assign w_dst         = addr[27:23];
   assign w_src_a       = addr[22:18];
   assign w_src_b       = addr[17:13];
   assign w_imm         = addr[7:0];
   assign w_unused_rsvd = ^addr[12:8];

   // Operands come from the pre-write register state, so aliased destinations read old values.
   assign w_a = r_regs[w_src_a];
   assign w_b = r_regs[w_src_b];

   always_comb begin
      w_rhs       = w_b;
      w_sum       = 9'd0;
      w_res       = 8'd0;
      w_c         = 1'b0;
      w_v         = 1'b0;
      w_we        = 1'b1;
      w_upd_flags = 1'b1;
      w_upd_out   = 1'b1;
      if (w_op == OpAddi) begin
         w_rhs = w_imm;
      end else if (w_op == OpInc || w_op == OpDec) begin
         w_rhs = 8'd1;
      end
      case (w_op)
         OpAdd, OpAddi, OpInc: begin
            w_sum = {1'b0, w_a} + {1'b0, w_rhs};
            w_res = w_sum[7:0];
            w_c   = w_sum[8];
            w_v   = (w_a[7] == w_rhs[7]) && (w_res[7] != w_a[7]);
         end
         OpSub, OpCmp, OpDec: begin
            // Bit 8 of the 9-bit difference is the borrow.
            w_sum = {1'b0, w_a} - {1'b0, w_rhs};
            w_res = w_sum[7:0];
            w_c   = w_sum[8];
            w_v   = (w_a[7] != w_rhs[7]) && (w_res[7] != w_a[7]);
            w_we  = (w_op != OpCmp);
         end
         OpAnd: w_res = w_a & w_b;
         OpOr:  w_res = w_a | w_b;
         OpXor: w_res = w_a ^ w_b;
         OpNot: w_res = ~w_a;
         OpShl: begin
            w_res = {w_a[6:0], 1'b0};
            w_c   = w_a[7];
         end
         OpShr: begin
            w_res = {1'b0, w_a[7:1]};
            w_c   = w_a[0];
         end
         OpLdi: w_res = w_imm;
         OpMov: w_res = w_a;
         OpOut: begin
            w_res       = w_a;
            w_we        = 1'b0;
            w_upd_flags = 1'b0;
         end
         default: begin
            w_we        = 1'b0;
            w_upd_flags = 1'b0;
            w_upd_out   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 8'd0;
         r_number <= 8'd0;
         r_opcode <= 4'd0;
         r_addr1  <= 5'd0;
         r_addr2  <= 5'd0;
         r_addr3  <= 5'd0;
         r_flags  <= 4'd0;
         r_out    <= 8'd0;
      end else begin
         r_number <= w_imm;
         r_opcode <= addr[31:28];
         r_addr1  <= w_dst;
         r_addr2  <= w_src_a;
         r_addr3  <= w_src_b;
         if (w_we) r_regs[w_dst] <= w_res;
         if (w_upd_flags) r_flags <= {w_v, w_res[7], w_c, (w_res == 8'd0)};
         if (w_upd_out) r_out <= w_res;
      end
   end

   assign number  = r_number;
   assign opcode  = r_opcode;
   assign addr1   = r_addr1;
   assign addr2   = r_addr2;
   assign addr3   = r_addr3;
   assign theflag = r_flags;
   assign output1 = r_out;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed test-plan scenarios plus random instructions,
// all compared against an integer-arithmetic reference model.
module tb_control_unit;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [7:0]  number;
   logic [3:0]  opcode;
   logic [4:0]  addr1;
   logic [4:0]  addr2;
   logic [4:0]  addr3;
   logic [3:0]  theflag;
   logic [7:0]  output1;

   int n_checks = 0;
   int n_errors = 0;

   int m_reg [32];
   int m_out, m_flag, m_num, m_op, m_a1, m_a2, m_a3;

   control_unit u_dut (
      .clk     (clk),
      .rst     (rst),
      .addr    (addr),
      .number  (number),
      .opcode  (opcode),
      .addr1   (addr1),
      .addr2   (addr2),
      .addr3   (addr3),
      .theflag (theflag),
      .output1 (output1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int sx(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   function automatic logic [31:0] enc(input int op, input int d, input int a, input int b,
                                       input int imm);
      logic [31:0] w;
      w = '0;
      w[31:28] = 4'(op);
      w[27:23] = 5'(d);
      w[22:18] = 5'(a);
      w[17:13] = 5'(b);
      w[7:0]   = 8'(imm);
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_reg[i] = 0;
      m_out = 0; m_flag = 0; m_num = 0; m_op = 0; m_a1 = 0; m_a2 = 0; m_a3 = 0;
   endtask

   task automatic model_exec(input logic [31:0] ins);
      int a, b, imm, rhs, full, res, sr, c, v, wr, fl;
      m_op = int'(ins[31:28]);
      m_a1 = int'(ins[27:23]);
      m_a2 = int'(ins[22:18]);
      m_a3 = int'(ins[17:13]);
      m_num = int'(ins[7:0]);
      a = m_reg[m_a2];
      b = m_reg[m_a3];
      imm = m_num;
      res = 0; c = 0; v = 0; wr = 1; fl = 1;
      case (m_op)
         0: begin wr = 0; fl = 0; end
         1, 9, 13: begin
            rhs  = (m_op == 1) ? b : (m_op == 9) ? imm : 1;
            full = a + rhs;
            res  = full % 256;
            c    = (full > 255) ? 1 : 0;
            sr   = sx(a) + sx(rhs);
            v    = (sr > 127 || sr < -128) ? 1 : 0;
         end
         2, 12, 14: begin
            rhs  = (m_op == 14) ? 1 : b;
            full = a - rhs;
            res  = (full + 256) % 256;
            c    = (a < rhs) ? 1 : 0;
            sr   = sx(a) - sx(rhs);
            v    = (sr > 127 || sr < -128) ? 1 : 0;
            wr   = (m_op == 12) ? 0 : 1;
         end
         3: res = a & b;
         4: res = a | b;
         5: res = a ^ b;
         6: res = 255 - a;
         7: begin res = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
         8: begin res = a / 2; c = a % 2; end
         10: res = imm;
         11: res = a;
         default: begin wr = 0; fl = 0; m_out = a; end
      endcase
      if (fl != 0) begin
         m_out  = res;
         m_flag = v * 8 + ((res >= 128) ? 4 : 0) + c * 2 + ((res == 0) ? 1 : 0);
      end
      if (wr != 0) m_reg[m_a1] = res;
   endtask

   task automatic check_all(input string ctx);
      check({ctx, ".output1"}, 32'(output1), 32'(m_out));
      check({ctx, ".theflag"}, 32'(theflag), 32'(m_flag));
      check({ctx, ".opcode"},  32'(opcode),  32'(m_op));
      check({ctx, ".number"},  32'(number),  32'(m_num));
      check({ctx, ".addr1"},   32'(addr1),   32'(m_a1));
      check({ctx, ".addr2"},   32'(addr2),   32'(m_a2));
      check({ctx, ".addr3"},   32'(addr3),   32'(m_a3));
   endtask

   task automatic step(input string ctx, input logic [31:0] ins);
      addr = ins;
      @(posedge clk);
      #1;
      model_exec(ins);
      check_all(ctx);
   endtask

   // Asserts reset between edges and checks outputs clear with no clock edge.
   task automatic async_reset(input string ctx);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all(ctx);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [31:0] ins;
      rst  = 1'b0;
      addr = '0;
      #1 rst = 1'b1;
      #2;
      model_reset();
      check_all("por");
      @(negedge clk);
      rst = 1'b0;

      step("ldi_r5", enc(10, 5, 0, 0, 8'h33));
      check("ldi_r5.const", 32'(output1), 32'h33);
      async_reset("midrst");
      step("mov_r6", enc(11, 6, 5, 0, 0));
      check("mov_r6.const_out", 32'(output1), 32'h00);
      check("mov_r6.const_flag", 32'(theflag), 32'b0001);

      step("ldi_r1", enc(10, 1, 0, 0, 8'h7F));
      step("ldi_r2", enc(10, 2, 0, 0, 8'h01));
      step("add_ovf", enc(1, 3, 1, 2, 0));
      check("add_ovf.const_out", 32'(output1), 32'h80);
      check("add_ovf.const_flag", 32'(theflag), 32'b1100);
      check("add_ovf.const_dec", {opcode, 3'b0, addr1, 3'b0, addr2, 3'b0, addr3},
            {4'd1, 3'b0, 5'd3, 3'b0, 5'd1, 3'b0, 5'd2});

      step("ldi_r4", enc(10, 4, 0, 0, 8'hFF));
      step("inc_r4", enc(13, 4, 4, 0, 0));
      check("inc_r4.const_out", 32'(output1), 32'h00);
      check("inc_r4.const_flag", 32'(theflag), 32'b0011);
      step("mov_r7", enc(11, 7, 4, 0, 0));
      check("mov_r7.const_out", 32'(output1), 32'h00);

      step("cmp_r1", enc(12, 0, 1, 1, 0));
      check("cmp_r1.const_out", 32'(output1), 32'h00);
      check("cmp_r1.const_flag", 32'(theflag), 32'b0001);
      step("out_r1", enc(15, 0, 1, 0, 0));
      check("out_r1.const_out", 32'(output1), 32'h7F);
      step("sub_r5", enc(2, 5, 2, 1, 0));
      check("sub_r5.const_out", 32'(output1), 32'h82);
      check("sub_r5.const_flag", 32'(theflag), 32'b0110);

      step("ldi_r8", enc(10, 8, 0, 0, 8'h01));
      step("shr_r9", enc(8, 9, 8, 0, 0));
      check("shr_r9.const_out", 32'(output1), 32'h00);
      check("shr_r9.const_flag", 32'(theflag), 32'b0011);
      step("out_r3", enc(15, 0, 3, 0, 0));
      check("out_r3.const_out", 32'(output1), 32'h80);
      check("out_r3.const_flag", 32'(theflag), 32'b0011);
      step("nop", enc(0, 17, 9, 21, 8'hA5));
      check("nop.const_out", 32'(output1), 32'h80);
      check("nop.const_flag", 32'(theflag), 32'b0011);

      step("raw_ldi", enc(10, 10, 0, 0, 8'h05));
      check("raw_ldi.const_out", 32'(output1), 32'h05);
      step("raw_addi", enc(9, 10, 10, 0, 8'h03));
      check("raw_addi.const_out", 32'(output1), 32'h08);
      step("raw_add", enc(1, 11, 10, 10, 0));
      check("raw_add.const_out", 32'(output1), 32'h10);

      for (int i = 0; i < 500; i++) begin
         ins = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            ins[27:26] = 2'b00;
            ins[22:21] = 2'b00;
            ins[17:16] = 2'b00;
         end
         step("rand", ins);
         if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Single-cycle control/execute unit for the small 8-bit processor.
- Each clock it accepts a 32-bit instruction word on `addr` and decodes it into opcode, register addresses and an 8-bit immediate.
- It executes the instruction against an internal 32 x 8-bit register file and ALU.
- It presents the registered decode fields, the ALU result (`output1`) and the status flags (`theflag`).

Parameters:
- None. Widths are fixed: 8-bit data, 32 registers, 4-bit opcode.

Ports:
- `clk` input 1 — rising-edge clock.
- `rst` input 1 — asynchronous, active-high reset.
- `addr` input 32 — instruction word.
- `number` output 8 — registered immediate field.
- `opcode` output 4 — registered opcode field.
- `addr1` output 5 — registered destination register index.
- `addr2` output 5 — registered source A register index.
- `addr3` output 5 — registered source B register index.
- `theflag` output 4 — status flags: [0]=Z, [1]=C, [2]=N, [3]=V.
- `output1` output 8 — registered result.

Behaviour:
- Instruction encoding:
  - opcode = `addr[31:28]`, addr1 = `addr[27:23]`, addr2 = `addr[22:18]`, addr3 = `addr[17:13]`, number = `addr[7:0]`.
  - `addr[12:8]` is reserved and ignored.
- Reset (`rst`=1, asynchronous):
  - All outputs go to 0 immediately.
  - All 32 registers are cleared to 0.
  - Reset dominates the clock; asserting it mid-stream discards the in-flight instruction.
- Timing:
  - On each rising edge with `rst`=0, the current `addr` is decoded.
  - Register operands R[addr2] and R[addr3] are read combinationally from the current instruction fields.
  - At the same edge: the result is written to R[addr1] when the op writes; `number`/`opcode`/`addr1`-`addr3`, `output1` and `theflag` are updated.
  - Latency is 1 cycle: outputs after edge k reflect the instruction present before edge k.
  - Back-to-back dependent instructions need no stalls: a value written at edge k is readable by the instruction sampled at edge k+1.
- Opcodes (A=R[addr2], B=R[addr3], I=number, D=R[addr1]):
  - 0 NOP: no write; `output1` and flags hold.
  - 1 ADD: D=A+B.
  - 2 SUB: D=A-B.
  - 3 AND: D=A&B.
  - 4 OR: D=A|B.
  - 5 XOR: D=A^B.
  - 6 NOT: D=~A.
  - 7 SHL: D=A<<1.
  - 8 SHR: D=A>>1, logical.
  - 9 ADDI: D=A+I.
  - 10 LDI: D=I.
  - 11 MOV: D=A.
  - 12 CMP: computes A-B; no register write.
  - 13 INC: D=A+1.
  - 14 DEC: D=A-1.
  - 15 OUT: `output1`=A; no write; flags hold.
- `output1` = the 8-bit result for opcodes 1-14.
- Arithmetic is modulo 256; results wrap.
- Flags (updated for opcodes 1-14):
  - Z = (result==0).
  - N = result[7].
  - ADD/ADDI/INC:
    - C = carry out of bit 7.
    - V = signed overflow (operands same sign, result sign differs).
  - SUB/CMP/DEC:
    - C = borrow (1 when unsigned A < subtrahend).
    - V = signed overflow (operand signs differ, result sign differs from A).
  - SHL: C = A[7]. SHR: C = A[0]. V=0 for both.
  - AND/OR/XOR/NOT/LDI/MOV: C=0, V=0.
- Register indices: all 32 registers, including R0, are general and writable.
- Aliasing: `addr1` may equal `addr2`/`addr3`. Operands are read before the write (e.g. ADD R1,R1,R1 doubles R1).
- No X propagation: any 32-bit `addr` value yields defined behaviour.

Test Plan:
- Reset:
  - Load R5=0x33, then assert `rst` between edges.
  - All outputs read 0 without a clock edge.
  - After release, MOV R6←R5 gives `output1`=0x00, Z=1.
- Signed overflow:
  - LDI R1=0x7F, LDI R2=0x01, ADD R3=R1+R2.
  - Expect `output1`=0x80, `theflag`=4'b1100 (V=1, N=1, C=0, Z=0).
  - Decode outputs show opcode=1, addr1=3, addr2=1, addr3=2.
- Carry wrap:
  - LDI R4=0xFF, INC R4←R4.
  - Expect `output1`=0x00, `theflag`=4'b0011 (C=1, Z=1).
  - A following MOV R7←R4 gives 0x00.
- Compare and borrow:
  - CMP R1,R1 → `output1`=0x00, Z=1, C=0; R1 still 0x7F.
  - SUB R5=R2-R1 → `output1`=0x82, C=1, N=1, V=0.
- Shift and OUT:
  - LDI R8=0x01, SHR R9←R8 → `output1`=0x00, C=1, Z=1.
  - OUT R3 → `output1`=0x80, flags unchanged (4'b0011).
  - NOP → all outputs hold except the decode fields.
- Read-after-write:
  - Consecutive edges: LDI R10=0x05, ADDI R10←R10+0x03, ADD R11=R10+R10.
  - Expect `output1` sequence 0x05, 0x08, 0x10 with no stalls.
